// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for a 5-stage rv32im pipeline: load-use stalls, multi-cycle MUL/DIV
// holds, branch flushes and saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MUL_LATENCY       = 1,
  parameter int unsigned DIV_LATENCY       = 32,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic                  ex_md_start,
  input  logic                  ex_md_is_div,
  input  logic                  ex_branch_taken,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  stall_ex,
  output logic                  bubble_ex_mem,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  md_done,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned MaxLat0 = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int unsigned MaxLat  = (MaxLat0 > LOAD_STALL_CYCLES) ? MaxLat0 : LOAD_STALL_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StLoadStall, StMdBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            md_pend_q, md_pend_d;
  logic            lu_hz;
  int unsigned     md_lat;

  always_comb begin
    lu_hz = ex_is_load && ex_reg_write && (ex_rd != '0) &&
            ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    md_lat = ex_md_is_div ? DIV_LATENCY : MUL_LATENCY;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    md_pend_d     = 1'b0;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    stall_ex      = 1'b0;
    bubble_ex_mem = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    // md_pend_q marks the cycle after the last MUL/DIV stall, which is always spent in StIdle
    md_done       = md_pend_q;
    unique case (state_q)
      StIdle: begin
        if (ex_md_start) begin
          if (md_lat == 1) begin
            md_done = 1'b1;
          end else begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_ex      = 1'b1;
            bubble_ex_mem = 1'b1;
            if (md_lat == 2) begin
              md_pend_d = 1'b1;
            end else begin
              state_d = StMdBusy;
              cnt_d   = CntW'(md_lat - 32'd3);
            end
          end
        end else if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (lu_hz) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = StLoadStall;
            cnt_d   = CntW'(LOAD_STALL_CYCLES - 32'd2);
          end
        end
      end
      StLoadStall: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StMdBusy: begin
        stall_pc      = 1'b1;
        stall_if_id   = 1'b1;
        stall_ex      = 1'b1;
        bubble_ex_mem = 1'b1;
        if (cnt_q == '0) begin
          state_d   = StIdle;
          md_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      bubble_id_ex  = 1'b0;
      stall_ex      = 1'b0;
      bubble_ex_mem = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      md_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      md_pend_q    <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_pend_q <= md_pend_d;
      if (stall_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_if_id && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  // A MUL/DIV start and a taken branch can never legally coincide while the unit is idle
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> !(ex_md_start && ex_branch_taken));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench for hazard_control_unit against a countdown-based reference model.
module tb_hazard_control_unit;

  localparam int unsigned RW   = 5;
  localparam int unsigned LSC  = 3;
  localparam int unsigned MULL = 1;
  localparam int unsigned DIVL = 5;
  localparam int unsigned CW   = 5;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int          NCYC = 3000;

  typedef struct packed {
    logic [7:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_reg_write, ex_is_load, ex_md_start, ex_md_is_div;
  logic ex_branch_taken;
  logic stall_pc, stall_if_id, bubble_id_ex, stall_ex, bubble_ex_mem;
  logic flush_if_id, flush_id_ex, md_done;
  logic [CW-1:0] stall_cycles, flush_count;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  hazard_control_unit #(
    .REG_ADDR_W(RW), .LOAD_STALL_CYCLES(LSC), .MUL_LATENCY(MULL),
    .DIV_LATENCY(DIVL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div), .ex_branch_taken(ex_branch_taken),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .stall_ex(stall_ex), .bubble_ex_mem(bubble_ex_mem), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pick_reg();
    int r = $urandom_range(0, 3);
    return (r == 0) ? RW'(0) : (r == 1) ? RW'(5) : (r == 2) ? RW'(6) : RW'($urandom);
  endfunction

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {stall_pc, stall_if_id, bubble_id_ex, stall_ex, bubble_ex_mem,
             flush_if_id, flush_id_ex, md_done};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
      end
      total++;
      if (stall_cycles !== e.sc) begin
        bad++;
        $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, e.sc);
      end
      total++;
      if (flush_count !== e.fc) begin
        bad++;
        $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, flush_count, e.fc);
      end
    end
  end

  initial begin
    // Model state: remaining load-stall cycles, remaining MUL/DIV stall cycles,
    // cycles until md_done (-1: none pending), and the two counters.
    int ld_left = 0, md_left = 0, done_in = -1, m_sc = 0, m_fc = 0;
    int rst_div = 150;
    rst = 1'b1;
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_reg_write, ex_is_load} = '0;
    {ex_md_start, ex_md_is_div, ex_branch_taken} = '0;
    @(posedge clk);
    for (int i = 0; i < NCYC; i++) begin
      exp_t e;
      bit spc, sif, bub, sex, bem, fl, dn, hz;
      int lat;
      #1;
      if (i == 1500) rst_div = 400;
      rst             = (i < 2) || ($urandom_range(0, rst_div - 1) == 0);
      id_rs1          = pick_reg();
      id_rs2          = pick_reg();
      ex_rd           = pick_reg();
      id_rs1_used     = $urandom_range(0, 3) != 0;
      id_rs2_used     = $urandom_range(0, 1) != 0;
      ex_reg_write    = $urandom_range(0, 3) != 0;
      ex_is_load      = $urandom_range(0, 1) != 0;
      ex_md_start     = $urandom_range(0, 9) == 0;
      ex_md_is_div    = $urandom_range(0, 1) != 0;
      ex_branch_taken = !ex_md_start && ($urandom_range(0, 7) == 0);

      {spc, sif, bub, sex, bem, fl, dn} = '0;
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
      if (rst) begin
        ld_left = 0; md_left = 0; done_in = -1; m_sc = 0; m_fc = 0;
      end else begin
        hz = ex_is_load && ex_reg_write && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        dn = (done_in == 0);
        if (done_in >= 0) done_in--;
        if (ld_left > 0) begin
          {spc, sif, bub} = 3'b111;
          ld_left--;
        end else if (md_left > 0) begin
          {spc, sif, sex, bem} = 4'b1111;
          md_left--;
        end else if (ex_md_start) begin
          lat = ex_md_is_div ? DIVL : MULL;
          if (lat == 1) dn = 1'b1;
          else begin
            {spc, sif, sex, bem} = 4'b1111;
            md_left = lat - 2;
            done_in = lat - 2;
          end
        end else if (ex_branch_taken) begin
          fl = 1'b1;
        end else if (hz) begin
          {spc, sif, bub} = 3'b111;
          ld_left = LSC - 1;
        end
        if (spc && m_sc < CMAX) m_sc++;
        if (fl && m_fc < CMAX) m_fc++;
      end
      e.ctl = {spc, sif, bub, sex, bem, fl, fl, dn};
      q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want=0", q.size());
    end
    total++;
    if (total < 3 * NCYC) begin
      bad++;
      $display("FAIL monitor_count got=%0d want>=%0d", total, 3 * NCYC);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
